// File: rtl/fp_wb_sched_if.sv
// Producer-side handshake bundle for the FP writeback scheduler.
// Carries the FPU result path and the FP load / int-to-FP move path.
// The scheduler uses the slave view; the producers (or a bench) use the master view.
interface fp_wb_sched_if #(
  parameter int XLEN = 32
);

  logic            fpu_valid_i;
  logic [4:0]      fpu_rd_i;
  logic [XLEN-1:0] fpu_data_i;
  logic            fpu_ready_o;

  logic            lsu_valid_i;
  logic [4:0]      lsu_rd_i;
  logic [XLEN-1:0] lsu_data_i;
  logic            lsu_ready_o;

  modport master (
    output fpu_valid_i, fpu_rd_i, fpu_data_i,
    input  fpu_ready_o,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  lsu_ready_o
  );

  modport slave (
    input  fpu_valid_i, fpu_rd_i, fpu_data_i,
    output fpu_ready_o,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    output lsu_ready_o
  );

endinterface

// File: rtl/fp_wb_sched.sv
// FP register file writeback scheduler and busy scoreboard.
// - Round-robin arbiter between the FPU result path and the LSU/move path.
// - The winner becomes a registered write {fregwrite_o, frd_o, wdata_o}.
// - Per-register busy bits give the issue stage a source/destination hazard.
// Optional build macro FP_WB_BYPASS_EN: sources matching the register written
// this cycle are forwarded (fwd_hit_o/fwd_data_o) and masked out of hazard_o.
// Without it, fwd_hit_o/fwd_data_o are tied to zero.
module fp_wb_sched #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  fp_wb_sched_if.slave    prod,
  input  logic            issue_set_i,
  input  logic [4:0]      issue_rd_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  input  logic [4:0]      rs3_i,
  output logic            hazard_o,
  output logic [2:0]      fwd_hit_o,
  output logic [XLEN-1:0] fwd_data_o,
  input  logic            flush_i,
  output logic            fregwrite_o,
  output logic [4:0]      frd_o,
  output logic [XLEN-1:0] wdata_o
);

  // Round-robin pointer: 0 prefers the FPU, 1 prefers the LSU on contention.
  logic                prio_d, prio_q;
  logic                fregwrite_d, fregwrite_q;
  logic [4:0]          frd_d, frd_q;
  logic [XLEN-1:0]     wdata_d, wdata_q;
  logic [NUM_REGS-1:0] busy_d, busy_q;

  logic                gnt_fpu_s;
  logic                gnt_lsu_s;
  logic [2:0]          src_busy_s;
  logic [2:0]          fwd_hit_s;
  logic                hazard_s;

  // Grant one requester; prio_q only matters when both are valid.
  always_comb begin
    gnt_fpu_s = 1'b0;
    gnt_lsu_s = 1'b0;
    if (prod.fpu_valid_i && prod.lsu_valid_i) begin
      if (prio_q) begin
        gnt_lsu_s = 1'b1;
      end else begin
        gnt_fpu_s = 1'b1;
      end
    end else if (prod.fpu_valid_i) begin
      gnt_fpu_s = 1'b1;
    end else if (prod.lsu_valid_i) begin
      gnt_lsu_s = 1'b1;
    end else begin
      gnt_fpu_s = 1'b0;
      gnt_lsu_s = 1'b0;
    end
  end

  assign prod.fpu_ready_o = gnt_fpu_s;
  assign prod.lsu_ready_o = gnt_lsu_s;

  // Next priority points at whoever lost; an idle cycle keeps the pointer.
  always_comb begin
    prio_d = prio_q;
    if (gnt_fpu_s) begin
      prio_d = 1'b1;
    end else if (gnt_lsu_s) begin
      prio_d = 1'b0;
    end else begin
      prio_d = prio_q;
    end
  end

  // Build the next register-file write; address/data hold when nothing is granted.
  always_comb begin
    fregwrite_d = gnt_fpu_s | gnt_lsu_s;
    frd_d       = frd_q;
    wdata_d     = wdata_q;
    if (gnt_fpu_s) begin
      frd_d   = prod.fpu_rd_i;
      wdata_d = prod.fpu_data_i;
    end else if (gnt_lsu_s) begin
      frd_d   = prod.lsu_rd_i;
      wdata_d = prod.lsu_data_i;
    end else begin
      frd_d   = frd_q;
      wdata_d = wdata_q;
    end
  end

  // Scoreboard update: flush or the current write clears, then a new issue sets.
  // The set is applied last so a newer producer keeps ownership of the register.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = {NUM_REGS{1'b0}};
    end else if (fregwrite_q) begin
      busy_d[frd_q] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue_set_i) begin
      busy_d[issue_rd_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  // Hazard from the current scoreboard; forwarded sources are not stalls.
  always_comb begin
    src_busy_s = {busy_q[rs3_i], busy_q[rs2_i], busy_q[rs1_i]};
`ifdef FP_WB_BYPASS_EN
    fwd_hit_s[0] = fregwrite_q & (frd_q == rs1_i);
    fwd_hit_s[1] = fregwrite_q & (frd_q == rs2_i);
    fwd_hit_s[2] = fregwrite_q & (frd_q == rs3_i);
`else
    fwd_hit_s = 3'b000;
`endif
    // The destination term is never masked: a WAW must wait for the bit to clear.
    hazard_s = (|(src_busy_s & ~fwd_hit_s)) | busy_q[issue_rd_i];
  end

  assign hazard_o  = hazard_s;
  assign fwd_hit_o = fwd_hit_s;
`ifdef FP_WB_BYPASS_EN
  assign fwd_data_o = wdata_q;
`else
  assign fwd_data_o = {XLEN{1'b0}};
`endif

  // State registers; reset drops any pending write and clears the scoreboard.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q      <= 1'b0;
      fregwrite_q <= 1'b0;
      frd_q       <= 5'd0;
      wdata_q     <= {XLEN{1'b0}};
      busy_q      <= {NUM_REGS{1'b0}};
    end else begin
      prio_q      <= prio_d;
      fregwrite_q <= fregwrite_d;
      frd_q       <= frd_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign fregwrite_o = fregwrite_q;
  assign frd_o       = frd_q;
  assign wdata_o     = wdata_q;

endmodule

// File: tb/tb_fp_wb_sched.sv
// Self-checking bench for fp_wb_sched: directed scenarios plus a randomized
// run against a behavioural model (busy table, round-robin winner, pending write).
module tb_fp_wb_sched;

  localparam int XLEN = 32;
`ifdef FP_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            issue_set_i;
  logic [4:0]      issue_rd_i, rs1_i, rs2_i, rs3_i;
  logic            hazard_o;
  logic [2:0]      fwd_hit_o;
  logic [XLEN-1:0] fwd_data_o;
  logic            flush_i;
  logic            fregwrite_o;
  logic [4:0]      frd_o;
  logic [XLEN-1:0] wdata_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  fp_wb_sched_if #(.XLEN(XLEN)) bus ();

  fp_wb_sched #(.NUM_REGS(32), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .prod(bus),
    .issue_set_i(issue_set_i), .issue_rd_i(issue_rd_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i),
    .hazard_o(hazard_o), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
    .flush_i(flush_i), .fregwrite_o(fregwrite_o), .frd_o(frd_o), .wdata_o(wdata_o)
  );

  // Reference model state
  bit          m_busy [32];
  int          m_prio;          // 0 = FPU favoured, 1 = LSU favoured
  bit          m_wr;
  logic [4:0]  m_frd;
  logic [31:0] m_wdata;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_prio = 0; m_wr = 1'b0; m_frd = 5'd0; m_wdata = 32'd0;
  endtask

  // -1 none, 0 FPU, 1 LSU
  function automatic int model_winner();
    if (bus.fpu_valid_i && bus.lsu_valid_i) return m_prio;
    if (bus.fpu_valid_i) return 0;
    if (bus.lsu_valid_i) return 1;
    return -1;
  endfunction

  function automatic logic [2:0] model_fwd();
    logic [2:0] r;
    r = 3'b000;
    if (BYP && m_wr) begin
      r[0] = (m_frd == rs1_i);
      r[1] = (m_frd == rs2_i);
      r[2] = (m_frd == rs3_i);
    end
    return r;
  endfunction

  function automatic bit model_hazard();
    logic [2:0] f;
    f = model_fwd();
    return (m_busy[rs1_i] && !f[0]) || (m_busy[rs2_i] && !f[1]) ||
           (m_busy[rs3_i] && !f[2]) || m_busy[issue_rd_i];
  endfunction

  function automatic logic [31:0] model_fwd_data();
    return BYP ? m_wdata : 32'd0;
  endfunction

  task automatic idle();
    bus.fpu_valid_i = 1'b0; bus.fpu_rd_i = 5'd0; bus.fpu_data_i = 32'd0;
    bus.lsu_valid_i = 1'b0; bus.lsu_rd_i = 5'd0; bus.lsu_data_i = 32'd0;
    issue_set_i = 1'b0; issue_rd_i = 5'd0; flush_i = 1'b0;
    rs1_i = 5'd0; rs2_i = 5'd0; rs3_i = 5'd0;
  endtask

  // Advance one clock edge and move the model forward with the same inputs.
  task automatic tick();
    int w;
    bit nb [32];
    w = model_winner();
    nb = m_busy;
    if (flush_i) begin
      foreach (nb[i]) nb[i] = 1'b0;
    end else if (m_wr) begin
      nb[m_frd] = 1'b0;
    end
    if (issue_set_i) nb[issue_rd_i] = 1'b1;
    @(posedge clk_i);
    m_busy = nb;
    if (w == 0) begin
      m_wr = 1'b1; m_frd = bus.fpu_rd_i; m_wdata = bus.fpu_data_i; m_prio = 1;
    end else if (w == 1) begin
      m_wr = 1'b1; m_frd = bus.lsu_rd_i; m_wdata = bus.lsu_data_i; m_prio = 0;
    end else begin
      m_wr = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (fregwrite_o !== 1'b0) begin errors++; $display("FAIL reset_fregwrite got=%b exp=0", fregwrite_o); end
    checks++; if (frd_o !== 5'd0) begin errors++; $display("FAIL reset_frd got=%0d exp=0", frd_o); end
    checks++; if (wdata_o !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", wdata_o); end
    checks++; if (fwd_hit_o !== 3'b000) begin errors++; $display("FAIL reset_fwd_hit got=%b exp=000", fwd_hit_o); end
    checks++; if (fwd_data_o !== 32'd0) begin errors++; $display("FAIL reset_fwd_data got=%h exp=0", fwd_data_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    checks++; if (fregwrite_o !== 1'b0) begin errors++; $display("FAIL post_reset_fregwrite got=%b exp=0", fregwrite_o); end
    for (int i = 0; i < 32; i++) begin
      rs1_i = 5'(i); rs2_i = 5'(i); rs3_i = 5'(i); issue_rd_i = 5'(i);
      #1;
      checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL reset_hazard rs=%0d got=%b exp=0", i, hazard_o); end
    end
    idle();
    bus.fpu_valid_i = 1'b1; bus.lsu_valid_i = 1'b1;
    #1;
    checks++; if (bus.fpu_ready_o !== 1'b1 || bus.lsu_ready_o !== 1'b0)
      begin errors++; $display("FAIL reset_first_grant got fpu=%b lsu=%b exp fpu=1 lsu=0", bus.fpu_ready_o, bus.lsu_ready_o); end
    idle();
    #1;
  endtask

  task automatic test_contention();
    logic [4:0] exp_rd [4];
    logic [31:0] exp_data [4];
    exp_rd = '{5'd3, 5'd7, 5'd3, 5'd7};
    exp_data = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000};
    idle();
    bus.fpu_valid_i = 1'b1; bus.fpu_rd_i = 5'd3; bus.fpu_data_i = 32'h3F800000;
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd7; bus.lsu_data_i = 32'h40000000;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.fpu_ready_o !== (c % 2 == 0) || bus.lsu_ready_o !== (c % 2 == 1))
        begin errors++; $display("FAIL contention_grant c=%0d got fpu=%b lsu=%b", c, bus.fpu_ready_o, bus.lsu_ready_o); end
      tick();
      checks++; if (fregwrite_o !== 1'b1 || frd_o !== exp_rd[c] || wdata_o !== exp_data[c])
        begin errors++; $display("FAIL contention_write c=%0d got we=%b rd=%0d data=%h exp we=1 rd=%0d data=%h",
                                 c, fregwrite_o, frd_o, wdata_o, exp_rd[c], exp_data[c]); end
    end
    idle();
    tick();
    checks++; if (fregwrite_o !== 1'b0 || frd_o !== 5'd7 || wdata_o !== 32'h40000000)
      begin errors++; $display("FAIL idle_hold got we=%b rd=%0d data=%h exp we=0 rd=7 data=40000000", fregwrite_o, frd_o, wdata_o); end
    rs1_i = 5'd3; rs2_i = 5'd7;
    #1;
    checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL unmatched_write_hazard got=%b exp=0", hazard_o); end
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    issue_set_i = 1'b1; issue_rd_i = 5'd5;
    #1;
    checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL sb_issue_cycle got=%b exp=0", hazard_o); end
    tick();
    issue_set_i = 1'b0; issue_rd_i = 5'd0; rs1_i = 5'd1; rs2_i = 5'd5; rs3_i = 5'd2;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL sb_busy c=%0d got=%b exp=1", c, hazard_o); end
      tick();
    end
    bus.fpu_valid_i = 1'b1; bus.fpu_rd_i = 5'd5; bus.fpu_data_i = 32'hC0490FDB;
    #1;
    checks++; if (hazard_o !== 1'b1 || bus.fpu_ready_o !== 1'b1)
      begin errors++; $display("FAIL sb_grant got hazard=%b ready=%b exp 1 1", hazard_o, bus.fpu_ready_o); end
    tick();
    bus.fpu_valid_i = 1'b0;
    #1;
    checks++; if (fregwrite_o !== 1'b1 || frd_o !== 5'd5) begin errors++; $display("FAIL sb_write got we=%b rd=%0d exp we=1 rd=5", fregwrite_o, frd_o); end
    if (BYP) begin
      checks++; if (hazard_o !== 1'b0 || fwd_hit_o !== 3'b010 || fwd_data_o !== 32'hC0490FDB)
        begin errors++; $display("FAIL sb_bypass got hazard=%b hit=%b data=%h exp 0 010 c0490fdb", hazard_o, fwd_hit_o, fwd_data_o); end
    end else begin
      checks++; if (hazard_o !== 1'b1 || fwd_hit_o !== 3'b000 || fwd_data_o !== 32'd0)
        begin errors++; $display("FAIL sb_nobypass got hazard=%b hit=%b data=%h exp 1 000 0", hazard_o, fwd_hit_o, fwd_data_o); end
    end
    tick();
    checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL sb_cleared got=%b exp=0", hazard_o); end
    idle();
  endtask

  task automatic test_same_cycle();
    idle();
    issue_set_i = 1'b1; issue_rd_i = 5'd9;
    tick();
    issue_set_i = 1'b0; issue_rd_i = 5'd0;
    bus.fpu_valid_i = 1'b1; bus.fpu_rd_i = 5'd9; bus.fpu_data_i = 32'h12345678;
    tick();
    bus.fpu_valid_i = 1'b0;
    issue_set_i = 1'b1; issue_rd_i = 5'd9;
    #1;
    checks++; if (fregwrite_o !== 1'b1 || frd_o !== 5'd9) begin errors++; $display("FAIL same_write got we=%b rd=%0d exp 1 9", fregwrite_o, frd_o); end
    tick();
    issue_set_i = 1'b0; issue_rd_i = 5'd0; rs1_i = 5'd9;
    #1;
    checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL same_set_wins got=%b exp=1", hazard_o); end
    idle();
  endtask

  task automatic test_flush();
    logic [4:0] regs [3];
    regs = '{5'd1, 5'd4, 5'd31};
    idle();
    for (int i = 0; i < 3; i++) begin
      issue_set_i = 1'b1; issue_rd_i = regs[i];
      tick();
    end
    issue_set_i = 1'b0; issue_rd_i = 5'd0;
    rs1_i = 5'd1; rs2_i = 5'd4; rs3_i = 5'd31;
    bus.fpu_valid_i = 1'b1; bus.fpu_rd_i = 5'd12; bus.fpu_data_i = 32'hAAAA5555;
    #1;
    checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL flush_before got=%b exp=1", hazard_o); end
    tick();
    flush_i = 1'b1; bus.fpu_rd_i = 5'd13; bus.fpu_data_i = 32'h5555AAAA;
    #1;
    checks++; if (fregwrite_o !== 1'b1 || frd_o !== 5'd12) begin errors++; $display("FAIL flush_inflight got we=%b rd=%0d exp 1 12", fregwrite_o, frd_o); end
    tick();
    flush_i = 1'b0; bus.fpu_valid_i = 1'b0;
    #1;
    checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL flush_clear got=%b exp=0", hazard_o); end
    checks++; if (fregwrite_o !== 1'b1 || frd_o !== 5'd13 || wdata_o !== 32'h5555AAAA)
      begin errors++; $display("FAIL flush_write got we=%b rd=%0d data=%h exp 1 13 5555aaaa", fregwrite_o, frd_o, wdata_o); end
    idle();
    tick();
  endtask

  task automatic test_async_reset();
    idle();
    bus.fpu_valid_i = 1'b1; bus.fpu_rd_i = 5'd2; bus.fpu_data_i = 32'h11111111;
    tick();
    bus.fpu_valid_i = 1'b0;
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd20; bus.lsu_data_i = 32'h22222222;
    #1;
    checks++; if (bus.lsu_ready_o !== 1'b1 || fregwrite_o !== 1'b1)
      begin errors++; $display("FAIL arst_setup got ready=%b we=%b exp 1 1", bus.lsu_ready_o, fregwrite_o); end
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    checks++; if (fregwrite_o !== 1'b0 || frd_o !== 5'd0) begin errors++; $display("FAIL arst_immediate got we=%b rd=%0d exp 0 0", fregwrite_o, frd_o); end
    bus.lsu_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    checks++; if (fregwrite_o !== 1'b0) begin errors++; $display("FAIL arst_no_write got=%b exp=0", fregwrite_o); end
    tick();
    bus.fpu_valid_i = 1'b1; bus.lsu_valid_i = 1'b1;
    #1;
    checks++; if (bus.fpu_ready_o !== 1'b1 || bus.lsu_ready_o !== 1'b0)
      begin errors++; $display("FAIL arst_prio got fpu=%b lsu=%b exp 1 0", bus.fpu_ready_o, bus.lsu_ready_o); end
    idle();
    #1;
  endtask

  task automatic test_random();
    bit hold_f = 1'b0, hold_l = 1'b0;
    int w;
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      if (!hold_f) begin
        bus.fpu_valid_i = ($urandom_range(0, 9) < 6);
        bus.fpu_rd_i = 5'($urandom_range(0, 7)); bus.fpu_data_i = $urandom;
      end
      if (!hold_l) begin
        bus.lsu_valid_i = ($urandom_range(0, 9) < 6);
        bus.lsu_rd_i = 5'($urandom_range(0, 7)); bus.lsu_data_i = $urandom;
      end
      issue_set_i = ($urandom_range(0, 3) == 0);
      issue_rd_i = 5'($urandom_range(0, 7));
      rs1_i = 5'($urandom_range(0, 9)); rs2_i = 5'($urandom_range(0, 9)); rs3_i = 5'($urandom_range(0, 9));
      flush_i = ($urandom_range(0, 31) == 0);
      #1;
      w = model_winner();
      checks++; if (bus.fpu_ready_o !== (w == 0) || bus.lsu_ready_o !== (w == 1))
        begin errors++; bad++; if (bad < 10) $display("FAIL rnd_grant c=%0d got fpu=%b lsu=%b exp winner=%0d", c, bus.fpu_ready_o, bus.lsu_ready_o, w); end
      checks++; if (hazard_o !== model_hazard())
        begin errors++; bad++; if (bad < 10) $display("FAIL rnd_hazard c=%0d got=%b exp=%b", c, hazard_o, model_hazard()); end
      checks++; if (fwd_hit_o !== model_fwd() || fwd_data_o !== model_fwd_data())
        begin errors++; bad++; if (bad < 10) $display("FAIL rnd_fwd c=%0d got hit=%b data=%h exp hit=%b data=%h", c, fwd_hit_o, fwd_data_o, model_fwd(), model_fwd_data()); end
      hold_f = bus.fpu_valid_i && (w != 0);
      hold_l = bus.lsu_valid_i && (w != 1);
      tick();
      checks++; if (fregwrite_o !== m_wr || frd_o !== m_frd || wdata_o !== m_wdata)
        begin errors++; bad++; if (bad < 10) $display("FAIL rnd_write c=%0d got we=%b rd=%0d data=%h exp we=%b rd=%0d data=%h",
                                                      c, fregwrite_o, frd_o, wdata_o, m_wr, m_frd, m_wdata); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_scoreboard();
    test_same_cycle();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_wb_sched.md
Name: fp_wb_sched

Overview:
Writeback scheduler and scoreboard for the FP register file's single write port. It arbitrates round-robin between two producers: the FPU result path and the FP load / int-to-FP move path. The winner is presented to the register file as a registered write (fregwrite/frd/wdata). A per-register busy scoreboard tells the issue stage when an FP source or destination operand is still pending.

Parameters:
NUM_REGS, 32, number of FP architectural registers (scoreboard depth)
XLEN, 32, FP register / writeback data width

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
fpu_valid_i  input  1  FPU result valid
fpu_rd_i  input  5  FPU destination register
fpu_data_i  input  XLEN  FPU result data
fpu_ready_o  output  1  FPU result accepted this cycle
lsu_valid_i  input  1  FP load / int-to-FP move valid
lsu_rd_i  input  5  LSU destination register
lsu_data_i  input  XLEN  LSU data
lsu_ready_o  output  1  LSU data accepted this cycle
issue_set_i  input  1  an FP-writing instruction issues; mark issue_rd_i busy
issue_rd_i  input  5  destination of the issuing instruction
rs1_i, rs2_i, rs3_i  input  5 each  source registers queried by issue
hazard_o  output  1  any queried source, or issue_rd_i, is busy
fwd_hit_o  output  3  per-source forward hit (bit0=rs1, bit1=rs2, bit2=rs3)
fwd_data_o  output  XLEN  forwarded write data (equals wdata_o)
flush_i  input  1  pipeline flush; clear scoreboard
fregwrite_o  output  1  register file write enable
frd_o  output  5  register file write address
wdata_o  output  XLEN  register file write data

Behaviour:
- Reset (async, rst_ni=0):
  - fregwrite_o=0, frd_o=0, wdata_o=0.
  - Scoreboard all clear; prio_q=0 (FPU preferred); fwd_hit_o=0, fwd_data_o=0.
  - Reset mid-transfer drops the pending registered write.
- Arbitration (combinational):
  - One valid requester: it is granted.
  - Both valid: the requester selected by prio_q is granted (0=FPU, 1=LSU).
  - The ready of the granted requester goes high in the same cycle; the loser's ready stays 0 and it must hold valid/rd/data stable.
  - On any grant, prio_q <= index of the non-granted requester.
  - No grant leaves prio_q unchanged.
- Write port:
  - A grant in cycle N registers {1, rd, data}, so fregwrite_o=1 in cycle N+1.
  - No grant in N gives fregwrite_o=0 in N+1; frd_o/wdata_o hold their last values.
  - Back-to-back grants produce one write per cycle (full throughput).
- Scoreboard (NUM_REGS bits, bit 0 is a normal register):
  - issue_set_i sets bit[issue_rd_i] at the clock edge.
  - fregwrite_o=1 clears bit[frd_o] at the edge ending that cycle.
  - Set and clear of the same rd in the same cycle: set wins, because the newer producer owns the register.
  - flush_i clears all bits. It does not cancel an in-flight fregwrite_o; if issue_set_i coincides with flush_i, the set still takes effect.
- Hazard:
  - hazard_o = busy[rs1_i] | busy[rs2_i] | busy[rs3_i] | busy[issue_rd_i], evaluated on the current-cycle scoreboard (WAW included).
  - A write arriving for an rd whose bit is already clear (no matching set) is still written to the register file; the scoreboard is unaffected.

Optional Feature:
Macro FP_WB_BYPASS_EN.
- Defined:
  - fwd_hit_o[k] = fregwrite_o & (frd_o == rsk).
  - fwd_data_o = wdata_o.
  - A source with fwd_hit_o[k]=1 is excluded from hazard_o in that cycle, so a dependent instruction issues in the same cycle the register file is written.
  - The issue_rd_i term is not masked.
- Undefined:
  - fwd_hit_o=0 and fwd_data_o=0 constantly.
  - hazard_o stays asserted through the fregwrite_o cycle and drops one cycle later, once the bit has been cleared.

Test Plan:
- Reset: hold rst_ni=0, then release with no stimulus -> fregwrite_o=0, hazard_o=0 for all rs; first dual-valid request grants the FPU.
- Contention: fpu_valid_i and lsu_valid_i held high for 4 cycles (FPU rd=3, data 0x3F800000; LSU rd=7, data 0x40000000) -> grant order FPU, LSU, FPU, LSU; fregwrite_o writes rd 3,7,3,7 in cycles 1-4 after the first grant.
- Scoreboard: issue_set_i rd=5, then rs2_i=5 queried each cycle; FPU writes rd=5 three cycles later -> hazard_o=1 until the write.
  - Bypass undefined: hazard_o falls the cycle after fregwrite_o.
  - FP_WB_BYPASS_EN defined: hazard_o falls in the fregwrite_o cycle with fwd_hit_o=3'b010 and fwd_data_o equal to the written data.
- Same-cycle set and clear: fregwrite_o for rd=9 with issue_set_i rd=9 in the same cycle -> bit 9 remains busy; hazard_o=1 for rs1_i=9 afterwards.
- Flush: bits 1, 4 and 31 busy; pulse flush_i -> hazard_o=0 for all three next cycle; a write already in flight still asserts fregwrite_o.
- Async reset mid-operation: LSU granted in cycle N, rst_ni=0 asserted mid-cycle N -> fregwrite_o=0 immediately and no write occurs in N+1; prio_q back to FPU.
